// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller for the simple-cycle core.
// Drives the registered instruction memory with the fetch PC, captures the
// returned words into a 2-entry buffer and hands them to decode.
//
// Handshake (decode side): inst_valid/inst_data/inst_pc describe the buffer
// head; a word is consumed at a rising edge exactly when inst_valid and
// inst_ready are both 1 at that edge. inst_valid never depends on
// inst_ready, and the head stays stable until it is consumed or a redirect
// flushes the buffer (a redirect discards the head even if inst_ready=1).
module ifetch_ctrl #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] instruction,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
    output logic          busy,
    output logic          dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic          inflight;
    logic [AW-1:0] inflight_pc;
    logic [1:0]    count;
    logic [AW-1:0] pc0, pc1;
    logic [DW-1:0] data0, data1;

    logic          pop;
    logic          push;
    logic          issue;
    logic [2:0]    occ_after_pop;

    // Occupancy seen by a new issue: buffered words plus the outstanding read,
    // minus the word decode is taking this cycle. pop implies count >= 1, so
    // the subtraction cannot underflow.
    always_comb begin
        pop           = (count != 2'd0) && inst_ready;
        push          = inflight;
        occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue         = (state == FETCH) && run && !redirect_valid &&
                        (occ_after_pop < 3'd2);
    end

    // Fetch state, PC, outstanding read and 2-entry buffer; redirect wins
    // over issue, capture and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            pc0         <= '0;
            pc1         <= '0;
            data0       <= '0;
            data1       <= '0;
        end else begin
            case (state)
                IDLE:    if (run)  state <= FETCH;
                FETCH:   if (!run) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (redirect_valid) begin
                pc       <= redirect_pc;
                inflight <= 1'b0;
                count    <= 2'd0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + AW'(1);
                    inflight_pc <= pc;
                end

                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            pc0   <= inflight_pc;
                            data0 <= instruction;
                        end else begin
                            pc1   <= inflight_pc;
                            data1 <= instruction;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        pc0   <= pc1;
                        data0 <= data1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            pc0   <= inflight_pc;
                            data0 <= instruction;
                        end else begin
                            pc0   <= pc1;
                            data0 <= data1;
                            pc1   <= inflight_pc;
                            data1 <= instruction;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign iaddr      = pc;
    assign inst_valid = (count != 2'd0);
    assign inst_data  = inst_valid ? data0 : '0;
    assign inst_pc    = inst_valid ? pc0 : '0;
    assign busy       = inflight || (count != 2'd0);
    assign dbg_state  = state;

endmodule
